alu_mem_unit: RTL and testbench
===============================

Name: alu_mem_unit

Overview:
- Execute/memory slice of the single-cycle RISC-V datapath.
- Contains three functions:
  - the PC+4 incrementer
  - the 64-bit ALU driven by the 4-bit ALU control code
  - the data memory, addressed directly by the low bits of the ALU result
- Sits between the register-file/immediate-mux stage and the write-back mux.

Parameters:
- PC_W, 9, program-counter width.
- PC_INC, 4, constant added to the PC each instruction.
- DATA_W, 64, ALU operand/result and memory word width.
- DM_ADDRESS, 9, byte-address width into data memory (taken from alu_result[DM_ADDRESS-1:0]).
- ALU_CC_W, 4, ALU control-code width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all data-memory words.
- pc_in  in  PC_W  current PC.
- pc_next  out  PC_W  pc_in + PC_INC.
- alu_a  in  DATA_W  operand A (rs1).
- alu_b  in  DATA_W  operand B (rs2 or immediate).
- alu_cc  in  ALU_CC_W  operation select.
- alu_result  out  DATA_W  ALU result; also the memory address source.
- alu_zero  out  1  high when alu_result == 0.
- mem_read  in  1  read enable.
- mem_write  in  1  write enable.
- mem_wdata  in  DATA_W  store data (rs2).
- mem_rdata  out  DATA_W  load data.
- misalign  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Adder:
  - Purely combinational: pc_next = (pc_in + PC_INC) mod 2^PC_W.
  - Wraps: 508 -> 0 for PC_W=9.
- ALU: purely combinational, two's-complement, results truncated to DATA_W.
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL by alu_b[5:0]
  - 0101 SRL by alu_b[5:0]
  - 0110 SUB (a-b)
  - 0111 SLT signed (result 1 or 0)
  - 1000 SRA by alu_b[5:0]
  - 1001 SLTU unsigned
  - 1100 NOR
  - All other codes -> result 0.
  - ADD/SUB overflow wraps silently; no carry/overflow outputs.
  - alu_zero follows alu_result combinationally.
- Data memory storage:
  - 2^DM_ADDRESS bytes, organized as 2^(DM_ADDRESS-3) DATA_W words (64 words).
  - Word index = alu_result[DM_ADDRESS-1:3]; alu_result[2:0] ignored for indexing.
  - Upper address bits above DM_ADDRESS ignored (address wraps modulo 512 bytes).
- Data memory write: on rising clk when mem_write=1 and reset=0, word[index] <= mem_wdata. Full-word writes only.
- Data memory read: combinational. mem_rdata = word[index] when mem_read=1, else 0.
- mem_read and mem_write both high:
  - mem_rdata shows the pre-edge contents during the cycle.
  - The new value is visible after the edge.
- Reset:
  - Asserting reset immediately clears every word to 0, independent of clk.
  - While reset is high, writes are ignored and mem_rdata returns 0 for any read.
  - Reset asserted mid-operation discards the in-flight write.
  - Combinational outputs (pc_next, alu_result, alu_zero) are unaffected by reset.
- No handshake; every access completes in the cycle it is presented. Latency: reads/ALU 0 cycles, writes 1 edge.

Optional Feature:
- Macro DM_MISALIGN_CHECK_EN.
- Defined:
  - misalign = (mem_read | mem_write) & (alu_result[2:0] != 0).
  - A write with misalign=1 is suppressed (memory unchanged).
  - A read with misalign=1 returns 0.
- Not defined:
  - misalign tied to 0.
  - Low three address bits are simply ignored; access goes to the containing word.

Test Plan:
- pc_in=0 -> pc_next=4; pc_in=508 -> pc_next=0 (wrap).
- alu_a=7, alu_b=5:
  - cc 0010 -> 12, alu_zero=0
  - cc 0110 -> 2
  - cc 0000 -> 5
  - cc 0001 -> 7
  - alu_a=alu_b=5, cc 0110 -> 0, alu_zero=1.
- alu_a=-1 (all ones), alu_b=1:
  - cc 0111 (SLT) -> 1
  - cc 1001 (SLTU) -> 0
  - cc 0101 (SRL) -> 0x7FFF_FFFF_FFFF_FFFF
  - cc 1000 (SRA) -> all ones
  - cc 1111 -> 0.
- alu_result=16, mem_write=1, mem_wdata=0xDEADBEEF_CAFEF00D, one edge; then mem_read=1 -> mem_rdata=0xDEADBEEF_CAFEF00D; mem_read=0 -> 0; address 24 reads 0.
- Write 0x55 at address 8, then pulse reset between clock edges -> address 8 reads 0 immediately; write attempted while reset high is lost.
- With DM_MISALIGN_CHECK_EN, write at address 12 -> misalign=1, memory word 1 unchanged. Without it, the same write updates word 1 and misalign=0.

Source files
------------

// File: rtl/alu_mem_unit.sv
// alu_mem_unit: execute/memory slice of the single-cycle RISC-V datapath.
// Holds the PC+4 incrementer, the 64-bit ALU and a word-organised data memory.
//
// Ports:
//   clk         in   rising-edge clock for memory writes
//   reset       in   async active-high; clears every memory word
//   pc_in       in   current PC
//   pc_next     out  pc_in + PC_INC, wraps at 2^PC_W
//   alu_a       in   operand A (rs1)
//   alu_b       in   operand B (rs2 or immediate)
//   alu_cc      in   ALU operation select
//   alu_result  out  ALU result, also the data-memory byte address
//   alu_zero    out  alu_result == 0
//   mem_read    in   read enable (combinational read)
//   mem_write   in   write enable (full word, on rising clk)
//   mem_wdata   in   store data
//   mem_rdata   out  load data, 0 when not reading
//   misalign    out  misaligned-access flag
//
// Optional feature: define DM_MISALIGN_CHECK_EN to flag accesses whose low
// three address bits are nonzero, suppress such writes and zero such reads.
// Without it misalign is tied low and the low bits are ignored.
module alu_mem_unit #(
  parameter int PC_W       = 9,
  parameter int PC_INC     = 4,
  parameter int DATA_W     = 64,
  parameter int DM_ADDRESS = 9,
  parameter int ALU_CC_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_W-1:0]     pc_in,
  output logic [PC_W-1:0]     pc_next,
  input  logic [DATA_W-1:0]   alu_a,
  input  logic [DATA_W-1:0]   alu_b,
  input  logic [ALU_CC_W-1:0] alu_cc,
  output logic [DATA_W-1:0]   alu_result,
  output logic                alu_zero,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                misalign
);

  localparam int IDX_W = DM_ADDRESS - 3;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [ALU_CC_W-1:0] CC_AND  = 4'b0000;
  localparam logic [ALU_CC_W-1:0] CC_OR   = 4'b0001;
  localparam logic [ALU_CC_W-1:0] CC_ADD  = 4'b0010;
  localparam logic [ALU_CC_W-1:0] CC_XOR  = 4'b0011;
  localparam logic [ALU_CC_W-1:0] CC_SLL  = 4'b0100;
  localparam logic [ALU_CC_W-1:0] CC_SRL  = 4'b0101;
  localparam logic [ALU_CC_W-1:0] CC_SUB  = 4'b0110;
  localparam logic [ALU_CC_W-1:0] CC_SLT  = 4'b0111;
  localparam logic [ALU_CC_W-1:0] CC_SRA  = 4'b1000;
  localparam logic [ALU_CC_W-1:0] CC_SLTU = 4'b1001;
  localparam logic [ALU_CC_W-1:0] CC_NOR  = 4'b1100;

  // ---------------- PC incrementer ----------------
  assign pc_next = pc_in + PC_W'(PC_INC);

  // ---------------- ALU ----------------
  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_alu;

  assign w_shamt = alu_b[5:0];

  always_comb begin
    w_alu = '0;
    case (alu_cc)
      CC_AND:  w_alu = alu_a & alu_b;
      CC_OR:   w_alu = alu_a | alu_b;
      CC_ADD:  w_alu = alu_a + alu_b;
      CC_XOR:  w_alu = alu_a ^ alu_b;
      CC_SLL:  w_alu = alu_a << w_shamt;
      CC_SRL:  w_alu = alu_a >> w_shamt;
      CC_SUB:  w_alu = alu_a - alu_b;
      CC_SLT:  w_alu = {{(DATA_W-1){1'b0}},
                        $signed(alu_a) < $signed(alu_b)};
      CC_SRA:  w_alu = $unsigned($signed(alu_a) >>> w_shamt);
      CC_SLTU: w_alu = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
      CC_NOR:  w_alu = ~(alu_a | alu_b);
      default: w_alu = '0;
    endcase
  end

  assign alu_result = w_alu;
  assign alu_zero   = (w_alu == '0);

  // ---------------- Data memory ----------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_idx;
  logic              w_ok;

  assign w_idx = w_alu[DM_ADDRESS-1:3];

`ifdef DM_MISALIGN_CHECK_EN
  logic w_lo_nz;
  assign w_lo_nz  = (w_alu[2:0] != 3'b000);
  assign misalign = (mem_read | mem_write) & w_lo_nz;
  assign w_ok     = ~w_lo_nz;
`else
  assign misalign = 1'b0;
  assign w_ok     = 1'b1;
`endif

  // Reset wins over a write on the same edge, so an in-flight store is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (mem_write && w_ok) begin
      r_mem[w_idx] <= mem_wdata;
    end
  end

  // Read is combinational, so a same-cycle read+write sees the old word.
  always_comb begin
    mem_rdata = '0;
    if (mem_read && w_ok && !reset) begin
      mem_rdata = r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_alu_mem_unit.sv
// tb_alu_mem_unit: directed and randomized checks of alu_mem_unit
// against a behavioural model of the PC adder, ALU and data memory.
module tb_alu_mem_unit;

  logic        clk;
  logic        reset;
  logic [8:0]  pc_in;
  logic [8:0]  pc_next;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_cc;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] model_mem [64];

`ifdef DM_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  alu_mem_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_next    (pc_next),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cc     (alu_cc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the operation table with plain arithmetic.
  function automatic logic [63:0] ref_alu(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [3:0] cc);
    longint sa, sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b % 64);
    case (cc)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a * (64'd1 << sh);
      4'd5:  return a / (64'd1 << sh);
      4'd6:  return a + (~b + 64'd1);
      4'd7:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  return a[63] ? ~((~a) >> sh) : (a >> sh);
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd12: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [63:0] addr, input logic rd,
                                 input logic wr);
    return CHK_EN && (rd || wr) && (addr % 8 != 0);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] addr,
                                         input logic rd);
    if (!rd || ref_mis(addr, rd, 1'b0)) return 64'd0;
    return model_mem[(addr % 512) / 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [63:0] addr);
    alu_a  = addr;
    alu_b  = 64'd0;
    alu_cc = 4'b0010;
  endtask

  // Commit a model write for the current inputs, then pass the edge.
  task automatic tick();
    logic [63:0] ad;
    ad = ref_alu(alu_a, alu_b, alu_cc);
    if (mem_write && !reset && !ref_mis(ad, mem_read, mem_write))
      model_mem[(ad % 512) / 8] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  cc;
    logic [63:0] r;
  } alu_vec_t;

  alu_vec_t vecs [$];
  logic [63:0] ones;
  logic [63:0] ea;

  initial begin
    ones = '1;
    reset = 1'b1;
    pc_in = '0;
    alu_a = '0;
    alu_b = '0;
    alu_cc = 4'b0010;
    mem_read = 1'b1;
    mem_write = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    #1;
    chk("reset_rdata", mem_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_rdata", mem_rdata, 64'd0);

    // PC adder
    pc_in = 9'd0;
    #1 chk("pc_0", 64'(pc_next), 64'd4);
    pc_in = 9'd508;
    #1 chk("pc_wrap", 64'(pc_next), 64'd0);

    // ALU directed
    vecs.push_back('{64'd7, 64'd5, 4'b0010, 64'd12});
    vecs.push_back('{64'd7, 64'd5, 4'b0110, 64'd2});
    vecs.push_back('{64'd7, 64'd5, 4'b0000, 64'd5});
    vecs.push_back('{64'd7, 64'd5, 4'b0001, 64'd7});
    vecs.push_back('{64'd5, 64'd5, 4'b0110, 64'd0});
    vecs.push_back('{ones, 64'd1, 4'b0111, 64'd1});
    vecs.push_back('{ones, 64'd1, 4'b1001, 64'd0});
    vecs.push_back('{ones, 64'd1, 4'b0101, 64'h7FFF_FFFF_FFFF_FFFF});
    vecs.push_back('{ones, 64'd1, 4'b1000, ones});
    vecs.push_back('{ones, 64'd1, 4'b1111, 64'd0});
    mem_read = 1'b0;
    foreach (vecs[i]) begin
      alu_a = vecs[i].a;
      alu_b = vecs[i].b;
      alu_cc = vecs[i].cc;
      #1;
      chk($sformatf("alu_vec%0d", i), alu_result, vecs[i].r);
      chk($sformatf("zero_vec%0d", i), 64'(alu_zero),
          64'(vecs[i].r == 0));
    end

    // Memory: write 16, read back, read disabled, neighbour word
    @(negedge clk);
    set_addr(64'd16);
    mem_write = 1'b1;
    mem_wdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    @(negedge clk);
    mem_write = 1'b0;
    mem_read = 1'b1;
    #1 chk("rd16", mem_rdata, 64'hDEADBEEF_CAFEF00D);
    mem_read = 1'b0;
    #1 chk("rd16_off", mem_rdata, 64'd0);
    mem_read = 1'b1;
    set_addr(64'd24);
    #1 chk("rd24", mem_rdata, 64'd0);
    set_addr(64'd16 + 64'd512);
    #1 chk("rd16_wrap", mem_rdata, 64'hDEADBEEF_CAFEF00D);

    // Read+write same cycle: old value before edge, new after
    set_addr(64'd16);
    mem_write = 1'b1;
    mem_wdata = 64'h1111_2222_3333_4444;
    #1 chk("rw_pre", mem_rdata, 64'hDEADBEEF_CAFEF00D);
    tick();
    mem_write = 1'b0;
    #1 chk("rw_post", mem_rdata, 64'h1111_2222_3333_4444);

    // Write 0x55 at 8, async reset pulse between edges
    @(negedge clk);
    set_addr(64'd8);
    mem_write = 1'b1;
    mem_wdata = 64'h55;
    tick();
    mem_write = 1'b0;
    #1 chk("rd8", mem_rdata, 64'h55);
    reset = 1'b1;
    #1 chk("rd8_in_reset", mem_rdata, 64'd0);
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    reset = 1'b0;
    #1 chk("rd8_after_reset", mem_rdata, 64'd0);
    set_addr(64'd16);
    #1 chk("rd16_after_reset", mem_rdata, 64'd0);

    // Write attempted while reset high is lost
    @(negedge clk);
    set_addr(64'd8);
    reset = 1'b1;
    mem_write = 1'b1;
    mem_wdata = 64'h77;
    tick();
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    #1 chk("wr_in_reset_lost", mem_rdata, 64'd0);

    // Misaligned write at 12
    @(negedge clk);
    set_addr(64'd12);
    mem_read = 1'b0;
    mem_write = 1'b1;
    mem_wdata = 64'hABCD;
    #1 chk("mis12", 64'(misalign), 64'(CHK_EN));
    tick();
    mem_write = 1'b0;
    mem_read = 1'b1;
    set_addr(64'd8);
    #1 chk("word1_after_mis", mem_rdata, CHK_EN ? 64'd0 : 64'hABCD);
    mem_read = 1'b0;
    #1 chk("mis_idle", 64'(misalign), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      pc_in = 9'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        alu_cc = 4'b0010;
        alu_a = 64'($urandom_range(0, 63) * 8);
        if ($urandom_range(0, 7) == 0) alu_a += 64'($urandom_range(1, 7));
        if ($urandom_range(0, 3) == 0) alu_a += 64'd512;
        alu_b = 64'd0;
      end else begin
        alu_cc = 4'($urandom);
        alu_a = {$urandom, $urandom};
        alu_b = {$urandom, $urandom};
      end
      mem_read = 1'($urandom);
      mem_write = ($urandom_range(0, 2) == 0);
      mem_wdata = {$urandom, $urandom};
      ea = ref_alu(alu_a, alu_b, alu_cc);
      #1;
      chk("r_pc", 64'(pc_next), 64'((pc_in + 4) % 512));
      chk("r_alu", alu_result, ea);
      chk("r_zero", 64'(alu_zero), 64'(ea == 0));
      chk("r_mis", 64'(misalign), 64'(ref_mis(ea, mem_read, mem_write)));
      chk("r_rdata", mem_rdata, ref_rd(ea, mem_read));
      tick();
    end

    // Sweep every aligned word against the model
    @(negedge clk);
    mem_write = 1'b0;
    mem_read = 1'b1;
    for (int w = 0; w < 64; w++) begin
      set_addr(64'(w * 8));
      #1 chk($sformatf("sweep%0d", w), mem_rdata, model_mem[w]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
